// File: rtl/speck_key_schedule_pkg.sv
// Shared types and default parameters for the SPECK key-schedule block.
package speck_key_schedule_pkg;

  // Controller states; the encodings are visible on the debug state output.
  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_LOAD   = 2'd1,
    KS_STREAM = 2'd2
  } ks_state_e;

  // Speck32/64 defaults.
  localparam int KS_WORD_W    = 16;
  localparam int KS_KEY_WORDS = 4;
  localparam int KS_ROUNDS    = 22;
  localparam int KS_ALPHA     = 7;
  localparam int KS_BETA      = 2;

endpackage

// File: rtl/speck_key_schedule_if.sv
// Subkey stream bundle: valid/ready handshake plus round index and last flag.
interface speck_key_schedule_if
  import speck_key_schedule_pkg::*;
#(
  parameter int WORD_W = KS_WORD_W,
  parameter int ROUNDS = KS_ROUNDS
) ();

  localparam int IDX_W = $clog2(ROUNDS);

  logic [WORD_W-1:0] subkey;
  logic              subkey_valid;
  logic              subkey_ready;
  logic [IDX_W-1:0]  round_idx;
  logic              last;

  modport master (
    output subkey, subkey_valid, round_idx, last,
    input  subkey_ready
  );

  modport slave (
    input  subkey, subkey_valid, round_idx, last,
    output subkey_ready
  );

endinterface

// File: rtl/speck_ks_step.sv
// One SPECK key-schedule step, purely combinational:
//   nl = (k + ROR(l0, ALPHA)) ^ idx ;  nk = ROL(k, BETA) ^ nl
module speck_ks_step
  import speck_key_schedule_pkg::*;
#(
  parameter int WORD_W = KS_WORD_W,
  parameter int IDX_W  = 5,
  parameter int ALPHA  = KS_ALPHA,
  parameter int BETA   = KS_BETA
) (
  input  logic [WORD_W-1:0] k_i,
  input  logic [WORD_W-1:0] l0_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [WORD_W-1:0] nl_o,
  output logic [WORD_W-1:0] nk_o
);

  logic [WORD_W-1:0] l_ror;
  logic [WORD_W-1:0] k_rol;

  assign l_ror = (l0_i >> ALPHA) | (l0_i << (WORD_W - ALPHA));
  assign k_rol = (k_i << BETA) | (k_i >> (WORD_W - BETA));
  // Sum wraps modulo 2^WORD_W; the round index is zero-extended before the XOR.
  assign nl_o  = (k_i + l_ror) ^ WORD_W'(idx_i);
  assign nk_o  = k_rol ^ nl_o;

endmodule

// File: rtl/speck_key_schedule.sv
// SPECK key schedule: expands a stored master key into ROUNDS subkeys that
// stream out in round order over a valid/ready handshake.
// Optional macro KEY_CACHE_EN adds a ROUNDS-entry subkey cache with a
// registered random-access read port (for reverse-order decrypt use).
module speck_key_schedule
  import speck_key_schedule_pkg::*;
#(
  parameter int  WORD_W    = KS_WORD_W,
  parameter int  KEY_WORDS = KS_KEY_WORDS,
  parameter int  ROUNDS    = KS_ROUNDS,
  parameter int  ALPHA     = KS_ALPHA,
  parameter int  BETA      = KS_BETA,
  localparam int IDX_W     = $clog2(ROUNDS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WORD_W*KEY_WORDS-1:0] key_in,
  input  logic                        key_load,
  input  logic                        restart,
  speck_key_schedule_if.master        ks_if,
  output logic                        busy,
  input  logic [IDX_W-1:0]            rd_addr,
  output logic [WORD_W-1:0]           rd_data,
  output logic                        cache_valid,
  output logic [1:0]                  state_response
);

  ks_state_e                   state_q, state_d;
  logic [WORD_W*KEY_WORDS-1:0] master_q;
  logic [WORD_W-1:0]           k_q;
  logic [WORD_W-1:0]           l_q [KEY_WORDS-1];
  logic [IDX_W-1:0]            idx_q;
  logic                        valid_q;
  logic [WORD_W-1:0]           nl, nk;
  logic                        handshake, at_last, advance, start_load;

  assign at_last    = (idx_q == IDX_W'(ROUNDS - 1));
  assign handshake  = valid_q & ks_if.subkey_ready;
  assign advance    = handshake & ~at_last;
  assign start_load = (state_q == KS_IDLE) & key_load;

  speck_ks_step #(
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W),
    .ALPHA  (ALPHA),
    .BETA   (BETA)
  ) u_step (
    .k_i   (k_q),
    .l0_i  (l_q[0]),
    .idx_i (idx_q),
    .nl_o  (nl),
    .nk_o  (nk)
  );

  // Next-state logic: key_load and restart are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      KS_IDLE:   if (key_load || restart) state_d = KS_LOAD;
      KS_LOAD:   state_d = KS_STREAM;
      KS_STREAM: if (handshake && at_last) state_d = KS_IDLE;
      default:   state_d = KS_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= KS_IDLE;
    else     state_q <= state_d;
  end

  // Master key is captured only by a key_load seen in IDLE; restart reuses it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             master_q <= '0;
    else if (start_load) master_q <= key_in;
  end

  // k word, round index and valid flag; everything holds while ready is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q     <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        KS_LOAD: begin
          k_q     <= master_q[WORD_W-1:0];
          idx_q   <= '0;
          valid_q <= 1'b1;
        end
        KS_STREAM: begin
          if (handshake && at_last) begin
            valid_q <= 1'b0;
          end else if (advance) begin
            k_q   <= nk;
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // l words form a shift queue: each step drops l[0] and appends the new l.
  generate
    for (genvar gi = 0; gi < KEY_WORDS - 1; gi++) begin : g_l
      if (gi == KEY_WORDS - 2) begin : g_tail
        // Tail word receives the freshly computed l.
        always_ff @(posedge clk or posedge rst) begin
          if (rst)                     l_q[gi] <= '0;
          else if (state_q == KS_LOAD) l_q[gi] <= master_q[WORD_W*(gi+1) +: WORD_W];
          else if (advance)            l_q[gi] <= nl;
        end
      end else begin : g_body
        // Body words shift down one place per step.
        always_ff @(posedge clk or posedge rst) begin
          if (rst)                     l_q[gi] <= '0;
          else if (state_q == KS_LOAD) l_q[gi] <= master_q[WORD_W*(gi+1) +: WORD_W];
          else if (advance)            l_q[gi] <= l_q[gi+1];
        end
      end
    end
  endgenerate

  assign ks_if.subkey       = k_q;
  assign ks_if.subkey_valid = valid_q;
  assign ks_if.round_idx    = idx_q;
  assign ks_if.last         = valid_q & at_last;
  assign busy               = (state_q != KS_IDLE);
  assign state_response     = state_q;

`ifdef KEY_CACHE_EN
  logic [WORD_W-1:0] cache_q [ROUNDS];
  logic [WORD_W-1:0] rd_data_q;
  logic              cache_valid_q;

  // Cache write: the subkey at round_idx is stored on every accepted transfer.
  always_ff @(posedge clk) begin
    if (handshake) cache_q[idx_q] <= k_q;
  end

  // Registered read; addresses beyond the last round return zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       rd_data_q <= '0;
    else if (int'(rd_addr) < ROUNDS) rd_data_q <= cache_q[rd_addr];
    else                           rd_data_q <= '0;
  end

  // Cache is complete after the final handshake; a new master key invalidates it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cache_valid_q <= 1'b0;
    else if (start_load)              cache_valid_q <= 1'b0;
    else if (handshake && at_last)    cache_valid_q <= 1'b1;
  end

  assign rd_data     = rd_data_q;
  assign cache_valid = cache_valid_q;
`else
  logic unused_rd_addr;

  assign unused_rd_addr = ^rd_addr;
  assign rd_data        = '0;
  assign cache_valid    = 1'b0;
`endif

endmodule
